// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one uart_tx serializer.
// Watchdogs recover from a hung serializer or a stalled packet owner.
module uart_tx_arbiter #(
    parameter int N_REQ         = 4,
    parameter int GAP_CLKS      = 2,
    parameter int DONE_TIMEOUT  = 16384,
    parameter int STALL_TIMEOUT = 65535
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic               o_tx_avail,
    output logic [7:0]         o_tx_byte,
    input  logic               i_tx_done,
    output logic [N_REQ-1:0]   o_grant,
    output logic               o_busy,
    output logic               o_pkt_done,
    output logic               o_err
);

    localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int MAXT = (DONE_TIMEOUT > STALL_TIMEOUT) ? DONE_TIMEOUT
                                                         : STALL_TIMEOUT;
    localparam int CW   = $clog2(MAXT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT_DONE,
        GAP
    } state_t;

    state_t          state, state_n;
    logic [IW-1:0]   rr, rr_n;
    logic [IW-1:0]   g, g_n;
    logic [IW-1:0]   g_inc;
    logic            lock, lock_n;
    logic            last_flag, last_n;
    logic [7:0]      byte_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [N_REQ-1:0] grant_n;
    logic            ready_en;
    logic            avail;
    logic            pkt;
    logic            err;

    logic [N_REQ-1:0] rot;
    logic [IW-1:0]    off;
    logic [IW:0]      sum;
    logic [IW-1:0]    pick;
    logic             found;

    logic             sel_valid;
    logic             sel_last;
    logic [7:0]       sel_data;

    function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    // Rotate so bit 0 is the rr position; first set bit wins.
    always_comb begin
        rot   = N_REQ'({req_valid, req_valid} >> rr);
        found = 1'b0;
        off   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                off   = IW'(k);
            end
        end
        sum = {1'b0, rr} + {1'b0, off};
        if (sum >= (IW+1)'(N_REQ)) begin
            sum = sum - (IW+1)'(N_REQ);
        end
        pick = sum[IW-1:0];
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (g == IW'(k)) begin
                sel_valid = req_valid[k];
                sel_last  = req_last[k];
                sel_data  = req_data[k*8 +: 8];
            end
        end
    end

    assign g_inc = (g == IW'(N_REQ - 1)) ? '0 : g + 1'b1;

    always_comb begin
        state_n  = state;
        rr_n     = rr;
        g_n      = g;
        lock_n   = lock;
        last_n   = last_flag;
        byte_n   = o_tx_byte;
        cnt_n    = cnt;
        ready_en = 1'b0;
        avail    = 1'b0;
        pkt      = 1'b0;
        err      = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    g_n     = pick;
                    lock_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                if (sel_valid) begin
                    ready_en = 1'b1;
                    byte_n   = sel_data;
                    last_n   = sel_last;
                    state_n  = ISSUE;
                end else if (cnt == CW'(STALL_TIMEOUT)) begin
                    err     = 1'b1;
                    lock_n  = 1'b0;
                    rr_n    = g_inc;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ISSUE: begin
                avail   = 1'b1;
                cnt_n   = '0;
                state_n = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (i_tx_done) begin
                    pkt     = last_flag;
                    cnt_n   = '0;
                    state_n = GAP;
                end else if (cnt == CW'(DONE_TIMEOUT - 1)) begin
                    err     = 1'b1;
                    lock_n  = 1'b0;
                    rr_n    = g_inc;
                    cnt_n   = '0;
                    state_n = GAP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            GAP: begin
                if (cnt == CW'(GAP_CLKS - 1)) begin
                    cnt_n = '0;
                    if (lock && !last_flag) begin
                        state_n = LOAD;
                    end else begin
                        // A timeout already released the lock and moved rr.
                        if (lock) begin
                            rr_n = g_inc;
                        end
                        lock_n  = 1'b0;
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                lock_n  = 1'b0;
            end
        endcase
        grant_n = lock_n ? onehot(g_n) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr        <= '0;
            g         <= '0;
            lock      <= 1'b0;
            last_flag <= 1'b0;
            o_tx_byte <= '0;
            cnt       <= '0;
            o_grant   <= '0;
        end else begin
            state     <= state_n;
            rr        <= rr_n;
            g         <= g_n;
            lock      <= lock_n;
            last_flag <= last_n;
            o_tx_byte <= byte_n;
            cnt       <= cnt_n;
            o_grant   <= grant_n;
        end
    end

    assign req_ready  = onehot(g) & {N_REQ{ready_en}};
    assign o_tx_avail = avail;
    assign o_busy     = (state != IDLE);
    assign o_pkt_done = pkt;
    assign o_err      = err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter with a
// packet-level round-robin model and a fake serializer.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int GAP = 2;
    localparam int DTO = 100;
    localparam int STO = 50;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           o_tx_avail;
    logic [7:0]     o_tx_byte;
    logic           i_tx_done;
    logic [N-1:0]   o_grant;
    logic           o_busy;
    logic           o_pkt_done;
    logic           o_err;

    uart_tx_arbiter #(
        .N_REQ(N),
        .GAP_CLKS(GAP),
        .DONE_TIMEOUT(DTO),
        .STALL_TIMEOUT(STO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .o_tx_avail(o_tx_avail),
        .o_tx_byte(o_tx_byte),
        .i_tx_done(i_tx_done),
        .o_grant(o_grant),
        .o_busy(o_busy),
        .o_pkt_done(o_pkt_done),
        .o_err(o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         owner;
        logic [7:0] b;
        logic       last;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic [8:0] rq [N][$];
    logic [8:0] mq [N][$];
    exp_t sbq [$];
    int   exp_err [$];
    int   model_rr = 0;
    bit   hang = 0;
    int   t_valid = 0;
    int   t_ready = 0;
    int   t_avail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic add_byte(input int r, input logic [7:0] b, input logic l);
        rq[r].push_back({l, b});
        mq[r].push_back({l, b});
    endtask

    task automatic add_pkt(input int r, input int len);
        for (int k = 0; k < len; k++) begin
            add_byte(r, 8'($urandom), k == len - 1);
        end
    endtask

    // Whole packets leave in round-robin order from the rr pointer.
    task automatic run_model();
        int p;
        logic [8:0] x;
        exp_t e;
        forever begin
            p = -1;
            for (int k = 0; k < N; k++) begin
                if (p < 0 && mq[(model_rr + k) % N].size() > 0) begin
                    p = (model_rr + k) % N;
                end
            end
            if (p < 0) break;
            do begin
                x = mq[p].pop_front();
                e.owner = p;
                e.b = x[7:0];
                e.last = x[8];
                sbq.push_back(e);
            end while (!x[8]);
            model_rr = (p + 1) % N;
        end
    endtask

    function automatic bit pending();
        bit any = 0;
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) any = 1;
        end
        return any;
    endfunction

    task automatic drain();
        int t = 0;
        while ((pending() || sbq.size() > 0 || o_busy) && t < 8000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", t < 8000, 1);
    endtask

    // Requester driver: present queue head, pop on accept.
    initial begin
        logic [N-1:0] acc;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                if (rq[i].size() > 0) begin
                    req_valid[i]       = 1'b1;
                    req_data[i*8 +: 8] = rq[i][0][7:0];
                    req_last[i]        = rq[i][0][8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
        end
    end

    // Fake serializer: random frame time, byte must stay put.
    initial begin
        logic [7:0] b;
        int n;
        bit ok;
        bit ab;
        i_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (o_tx_avail && rst_n) begin
                b  = o_tx_byte;
                n  = $urandom_range(12, 40);
                ok = 1;
                ab = 0;
                for (int k = 0; k < n; k++) begin
                    @(negedge clk);
                    if (!rst_n) ab = 1;
                    if (!ab && o_tx_byte !== b) ok = 0;
                end
                if (!ab) chk("byte_stable", ok, 1);
                if (!ab && !hang) begin
                    @(posedge clk);
                    #1 i_tx_done = 1'b1;
                    @(posedge clk);
                    #1 i_tx_done = 1'b0;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT acts.
    initial begin
        bit   inflight = 0;
        logic cur_last = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                inflight = 0;
                continue;
            end
            if (!o_busy && |req_valid) t_valid = cyc;
            if (|req_ready) begin
                t_ready = cyc;
                chk("ready_without_valid", req_ready & ~req_valid, 0);
                chk("ready_vs_grant", req_ready, o_grant);
            end
            if (o_tx_avail) begin
                t_avail = cyc;
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_avail: got byte %0h expected none",
                             o_tx_byte);
                end else begin
                    e = sbq.pop_front();
                    chk("tx_byte", o_tx_byte, e.b);
                    chk("grant", o_grant, 1 << e.owner);
                    cur_last = e.last;
                    inflight = 1;
                    if (hang) exp_err.push_back(cyc + DTO);
                end
            end
            if (inflight && i_tx_done) begin
                chk("pkt_done", o_pkt_done, cur_last);
                inflight = 0;
            end else if (o_pkt_done) begin
                checks++;
                errors++;
                $display("FAIL spurious_pkt_done: got 1 expected 0");
            end
            if (o_err) begin
                chk("err_pkt_done_excl", o_pkt_done, 0);
                if (exp_err.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_err: got pulse at %0d expected none",
                             cyc);
                end else begin
                    chk("err_cycle", cyc, exp_err.pop_front());
                end
                inflight = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int d;
        logic [7:0] b;
        exp_t e;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", o_grant, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_avail", o_tx_avail, 0);
        chk("rst_byte", o_tx_byte, 0);
        chk("rst_pkt_done", o_pkt_done, 0);
        chk("rst_err", o_err, 0);
        chk("rst_ready", req_ready, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // single byte and latency
        @(negedge clk);
        add_byte(0, 8'hA5, 1'b1);
        run_model();
        drain();
        chk("lat_ready", t_ready, t_valid + 1);
        chk("lat_avail", t_avail, t_valid + 2);
        chk("grant_released", o_grant, 0);

        // packet lock: req1 3-byte packet ahead of req2
        @(negedge clk);
        add_byte(1, 8'h01, 1'b0);
        add_byte(1, 8'h02, 1'b0);
        add_byte(1, 8'h03, 1'b1);
        add_byte(2, 8'h5C, 1'b1);
        run_model();
        drain();

        // round robin, everyone continuously valid
        @(negedge clk);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) add_byte(i, 8'($urandom), 1'b1);
        end
        run_model();
        drain();

        // random packets
        for (int r = 0; r < 6; r++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                for (int p = 0; p < int'($urandom_range(0, 2)); p++) begin
                    add_pkt(i, $urandom_range(1, 4));
                end
            end
            run_model();
            drain();
        end

        // hung serializer
        @(negedge clk);
        hang = 1;
        add_byte(1, 8'($urandom), 1'b1);
        run_model();
        t = 0;
        while (!o_err && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("done_wd_seen", o_err, 1);
        @(negedge clk);
        chk("done_wd_grant", o_grant, 0);
        chk("done_wd_gap1", o_busy, 1);
        @(negedge clk);
        chk("done_wd_gap2", o_busy, 1);
        @(negedge clk);
        chk("done_wd_idle", o_busy, 0);
        hang = 0;
        drain();

        // stalled owner: req3 sends a non-last byte then goes quiet
        @(negedge clk);
        b = 8'($urandom);
        rq[3].push_back({1'b0, b});
        e.owner = 3;
        e.b = b;
        e.last = 1'b0;
        sbq.push_back(e);
        t = 0;
        while (!i_tx_done && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("stall_done_seen", i_tx_done, 1);
        d = cyc;
        exp_err.push_back(d + GAP + 1 + STO);
        t = 0;
        while (!o_err && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("stall_wd_seen", o_err, 1);
        @(negedge clk);
        chk("stall_wd_grant", o_grant, 0);
        model_rr = 0;
        add_pkt(2, 2);
        add_pkt(0, 1);
        run_model();
        drain();

        // reset in the middle of a byte
        @(negedge clk);
        add_byte(2, 8'($urandom), 1'b1);
        run_model();
        t = 0;
        while (!o_tx_avail && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("rst6_avail_seen", o_tx_avail, 1);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst6_busy", o_busy, 0);
        chk("rst6_grant", o_grant, 0);
        chk("rst6_byte", o_tx_byte, 0);
        chk("rst6_avail", o_tx_avail, 0);
        repeat (48) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        model_rr = 0;
        @(negedge clk);
        add_byte(3, 8'($urandom), 1'b1);
        add_byte(1, 8'($urandom), 1'b1);
        run_model();
        drain();

        chk("err_queue_empty", exp_err.size(), 0);
        chk("sb_queue_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
